// File: rtl/axis_stall_pkg.sv
// Shared types and defaults for the AXI-Stream stall scheduler.
// Entry fields are stored 32 bits wide so one struct serves any IDX_W/LEN_W up to 32.
package axis_stall_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_INTR = 8;
  localparam int DEF_LEN_W    = 8;
  localparam int DEF_IDX_W    = 16;
  localparam int ENT_IDX_W    = 32;
  localparam int ENT_LEN_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_STALL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic                 used;
    logic [ENT_IDX_W-1:0] beat;
    logic [ENT_LEN_W-1:0] len;
  } stall_ent_t;
endpackage

// File: rtl/axis_stall_table.sv
// Stall-entry storage with a lowest-address match encoder against the current beat count.
module axis_stall_table
  import axis_stall_pkg::*;
#(
  parameter int MAX_INTR = DEF_MAX_INTR,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int IDX_W    = DEF_IDX_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_we,
  input  logic [$clog2(MAX_INTR)-1:0] i_addr,
  input  logic [IDX_W-1:0]            i_beat,
  input  logic [LEN_W-1:0]            i_len,
  input  logic                        i_clear,
  input  logic                        i_rearm,
  input  logic [IDX_W-1:0]            i_cnt,
  input  logic                        i_consume,
  output logic                        o_hit,
  output logic [LEN_W-1:0]            o_len
);
  localparam int AW = $clog2(MAX_INTR);

  stall_ent_t          r_tab [MAX_INTR];
  logic [MAX_INTR-1:0] w_match;
  logic [AW-1:0]       w_sel;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < MAX_INTR; i++)
      w_match[i] = r_tab[i].valid && !r_tab[i].used && (r_tab[i].len != '0) &&
                   (r_tab[i].beat == ENT_IDX_W'(i_cnt));
  end

  // Descending scan so the lowest matching address wins.
  always_comb begin
    w_sel = '0;
    for (int i = MAX_INTR - 1; i >= 0; i--)
      if (w_match[i]) w_sel = AW'(i);
  end

  assign o_hit = |w_match;
  assign o_len = r_tab[w_sel].len[LEN_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_INTR; i++) r_tab[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < MAX_INTR; i++) begin
        r_tab[i].valid <= 1'b0;
        r_tab[i].used  <= 1'b0;
      end
    end else begin
      if (i_rearm)
        for (int i = 0; i < MAX_INTR; i++) r_tab[i].used <= 1'b0;
      if (i_consume) r_tab[w_sel].used <= 1'b1;
      if (i_we) begin
        r_tab[i_addr].valid <= 1'b1;
        r_tab[i_addr].used  <= 1'b0;
        r_tab[i_addr].beat  <= ENT_IDX_W'(i_beat);
        r_tab[i_addr].len   <= ENT_LEN_W'(i_len);
      end
    end
  end
endmodule

// File: rtl/axis_stall_scheduler.sv
// AXI-Stream pass-through that inserts programmed stall windows before selected beats.
module axis_stall_scheduler
  import axis_stall_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_INTR = DEF_MAX_INTR,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int IDX_W    = DEF_IDX_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [$clog2(MAX_INTR)-1:0] cfg_addr,
  input  logic [IDX_W-1:0]            cfg_beat,
  input  logic [LEN_W-1:0]            cfg_len,
  input  logic                        cfg_clear,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [IDX_W-1:0]            beat_cnt,
  input  logic [DATA_W-1:0]           s_tdata,
  input  logic                        s_tvalid,
  input  logic                        s_tlast,
  output logic                        s_tready,
  output logic [DATA_W-1:0]           m_tdata,
  output logic                        m_tvalid,
  output logic                        m_tlast,
  input  logic                        m_tready
);
  state_e           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0] r_beat_cnt;
  logic             w_hit, w_idle, w_fwd, w_acc;
  logic [LEN_W-1:0] w_hit_len;

  assign w_idle = (r_state == ST_IDLE);
  assign w_fwd  = (r_state == ST_PASS) && !w_hit;
  assign w_acc  = w_fwd && s_tvalid && m_tready;

  assign m_tvalid = w_fwd && s_tvalid;
  assign s_tready = w_fwd && m_tready;
  assign m_tdata  = s_tdata;
  assign m_tlast  = s_tlast;
  assign busy     = (r_state == ST_PASS) || (r_state == ST_STALL);
  assign done     = (r_state == ST_DONE);
  assign beat_cnt = r_beat_cnt;

  axis_stall_table #(.MAX_INTR(MAX_INTR), .LEN_W(LEN_W), .IDX_W(IDX_W)) u_tab (
    .clk       (clk),
    .rst       (rst),
    .i_we      (cfg_we && w_idle),
    .i_addr    (cfg_addr),
    .i_beat    (cfg_beat),
    .i_len     (cfg_len),
    .i_clear   (cfg_clear && w_idle),
    .i_rearm   (start && w_idle),
    .i_cnt     (r_beat_cnt),
    .i_consume ((r_state == ST_PASS) && w_hit),
    .o_hit     (w_hit),
    .o_len     (w_hit_len)
  );

  // The hit cycle in PASS is the first gated cycle; STALL covers the remaining len-1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_PASS;
      ST_PASS: begin
        if (w_hit) begin
          w_cnt_nxt = w_hit_len - LEN_W'(1);
          if (w_hit_len > LEN_W'(1)) w_state_nxt = ST_STALL;
        end else if (w_acc && s_tlast) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_STALL: begin
        w_cnt_nxt = r_cnt - LEN_W'(1);
        if (w_cnt_nxt == '0) w_state_nxt = ST_PASS;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_idle && start)
        r_beat_cnt <= '0;
      else if (w_acc && (r_beat_cnt != '1))
        r_beat_cnt <= r_beat_cnt + IDX_W'(1);
    end
  end
endmodule

// File: tb/tb_axis_stall_scheduler.sv
// Randomized bench: per-cycle comparison against a beat/stall-budget reference model.
module tb_axis_stall_scheduler;
  localparam int DATA_W = 32, MAX_INTR = 8, LEN_W = 8, IDX_W = 16, AW = 3;

  logic              clk = 1'b0;
  logic              rst, cfg_we, cfg_clear, start;
  logic [AW-1:0]     cfg_addr;
  logic [IDX_W-1:0]  cfg_beat, beat_cnt;
  logic [LEN_W-1:0]  cfg_len;
  logic              busy, done;
  logic [DATA_W-1:0] s_tdata, m_tdata;
  logic              s_tvalid, s_tlast, s_tready, m_tvalid, m_tlast, m_tready;

  axis_stall_scheduler #(.DATA_W(DATA_W), .MAX_INTR(MAX_INTR), .LEN_W(LEN_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_beat(cfg_beat),
    .cfg_len(cfg_len), .cfg_clear(cfg_clear), .start(start), .busy(busy), .done(done),
    .beat_cnt(beat_cnt), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit ref_vld [MAX_INTR];
  int ref_beat[MAX_INTR];
  int ref_len [MAX_INTR];
  int dut_gated;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Total stall budget owed before beat k: sum of enabled entry lengths targeting k.
  function automatic int stall_before(input int k);
    int s = 0;
    for (int i = 0; i < MAX_INTR; i++)
      if (ref_vld[i] && ref_beat[i] == k) s += ref_len[i];
    return s;
  endfunction

  task automatic cfg_write(input int a, input int b, input int l);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_beat = IDX_W'(b); cfg_len = LEN_W'(l);
    @(negedge clk);
    cfg_we = 1'b0;
    ref_vld[a] = 1'b1; ref_beat[a] = b; ref_len[a] = l;
  endtask

  task automatic cfg_clr();
    @(negedge clk);
    cfg_clear = 1'b1;
    @(negedge clk);
    cfg_clear = 1'b0;
    for (int i = 0; i < MAX_INTR; i++) ref_vld[i] = 1'b0;
  endtask

  // Runs one n-beat transaction; rnd randomizes valid/ready, bwr attempts a table write while busy.
  task automatic run_txn(input int n, input bit rnd, input bit bwr);
    logic [DATA_W-1:0] dat[$];
    int mb = 0, pend, cycles = 0;
    bit fin = 0;
    dut_gated = 0;
    for (int i = 0; i < n; i++) dat.push_back($urandom);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    pend = stall_before(0);
    while (!fin && cycles < 500) begin
      s_tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_tready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_tdata  = dat[mb];
      s_tlast  = (mb == n - 1);
      if (bwr) begin
        cfg_we = 1'b1; cfg_addr = AW'(7); cfg_beat = '0; cfg_len = LEN_W'(5);
      end
      #1;
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      chk("beat_cnt", beat_cnt, mb);
      if (s_tvalid && !m_tvalid) dut_gated++;
      if (pend > 0) begin
        chk("stall_mvalid", m_tvalid, 0);
        chk("stall_sready", s_tready, 0);
      end else begin
        chk("mvalid", m_tvalid, s_tvalid);
        chk("sready", s_tready, m_tready);
        if (s_tvalid) begin
          chk("mdata", m_tdata, dat[mb]);
          chk("mlast", m_tlast, mb == n - 1);
        end
      end
      @(posedge clk);
      cycles++;
      if (pend > 0) pend--;
      else if (s_tvalid && m_tready) begin
        mb++;
        if (mb == n) fin = 1;
        else pend = stall_before(mb);
      end
      @(negedge clk);
    end
    cfg_we = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
    if (!fin) chk("txn_timeout", 0, 1);
    #1;
    chk("done_pulse", done, 1);
    chk("busy_after", busy, 0);
    chk("final_beat_cnt", beat_cnt, n);
    @(negedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_clear = 1'b0; start = 1'b0;
    cfg_addr = '0; cfg_beat = '0; cfg_len = '0;
    s_tdata = '0; s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = 1'b1;
    for (int i = 0; i < MAX_INTR; i++) begin ref_vld[i] = 0; ref_beat[i] = 0; ref_len[i] = 0; end
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("idle_mvalid", m_tvalid, 0);
    chk("idle_sready", s_tready, 0);
    rst = 1'b0;

    // Empty table
    run_txn(4, 0, 0);
    chk("empty_gated", dut_gated, 0);

    // Mid-transaction stall, plus an entry past the final beat
    cfg_write(0, 2, 3);
    cfg_write(3, 9, 2);
    run_txn(6, 0, 0);
    chk("mid_gated", dut_gated, 3);

    // End-point stalls
    cfg_clr();
    cfg_write(0, 0, 1);
    cfg_write(1, 5, 2);
    run_txn(6, 0, 0);
    chk("endpt_gated", dut_gated, 3);

    // Same-beat entries and a len=0 entry
    cfg_clr();
    cfg_write(1, 3, 2);
    cfg_write(0, 3, 4);
    cfg_write(2, 1, 0);
    run_txn(6, 0, 0);
    chk("samebeat_gated", dut_gated, 6);

    // Backpressure with replay; second txn also tries a write while busy
    cfg_clr();
    cfg_write(0, 1, 2);
    run_txn(5, 1, 0);
    run_txn(5, 1, 1);
    run_txn(5, 0, 0);
    chk("replay_gated", dut_gated, 2);

    // Clear beats a simultaneous write
    @(negedge clk);
    cfg_clear = 1'b1; cfg_we = 1'b1; cfg_addr = '0; cfg_beat = '0; cfg_len = LEN_W'(3);
    @(negedge clk);
    cfg_clear = 1'b0; cfg_we = 1'b0;
    for (int i = 0; i < MAX_INTR; i++) ref_vld[i] = 1'b0;
    run_txn(3, 0, 0);
    chk("clear_prio_gated", dut_gated, 0);

    // Reset while stalled
    cfg_write(0, 1, 5);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1; s_tdata = $urandom;
    @(negedge clk);
    @(negedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_stalled", m_tvalid, 0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_beat_cnt", beat_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("abort_no_done", done, 0);
    end
    for (int i = 0; i < MAX_INTR; i++) ref_vld[i] = 1'b0;
    run_txn(4, 0, 0);
    chk("post_rst_gated", dut_gated, 0);

    // Random schedules
    for (int t = 0; t < 8; t++) begin
      int ne, nb;
      cfg_clr();
      ne = $urandom_range(0, 4);
      for (int e = 0; e < ne; e++)
        cfg_write($urandom_range(0, MAX_INTR - 1), $urandom_range(0, 7), $urandom_range(0, 4));
      nb = $urandom_range(1, 8);
      run_txn(nb, 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axis_stall_scheduler.md
AXIS_STALL_SCHEDULER -- requirements
Module: axis_stall_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning AXI-Stream tdata width.
REQ-002 SHALL have parameter MAX_INTR, default 8, meaning number of stall-table entries.
REQ-003 SHALL have parameter LEN_W, default 8, meaning width of one stall length.
REQ-004 SHALL have parameter IDX_W, default 16, meaning width of beat index and beat counter.
REQ-005 SHALL have ports, in order:
  - clk  in  1  single clock, all logic on rising edge.
  - rst  in  1  synchronous, active-high reset.
  - cfg_we  in  1  stall-table write strobe.
  - cfg_addr  in  $clog2(MAX_INTR)  entry index.
  - cfg_beat  in  IDX_W  beat index before which the stall occurs.
  - cfg_len  in  LEN_W  stall length in cycles; 0 disables the entry.
  - cfg_clear  in  1  invalidate all entries.
  - start  in  1  arm one transaction.
  - busy  out  1  transaction in progress.
  - done  out  1  one-cycle pulse after the tlast beat.
  - beat_cnt  out  IDX_W  accepted beats in the current transaction.
  - s_tdata/s_tvalid/s_tlast  in  DATA_W/1/1  upstream stream; s_tready  out  1.
  - m_tdata/m_tvalid/m_tlast  out  DATA_W/1/1  downstream stream; m_tready  in  1.

Function
REQ-006 SHALL implement FSM states IDLE, PASS, STALL, DONE.
REQ-007 SHALL transition IDLE->PASS on start; start SHALL be ignored in every other state.
REQ-008 SHALL hold busy=1 in PASS and STALL and 0 otherwise; done SHALL be 1 only in DONE.
REQ-009 SHALL drive m_tvalid=0 and s_tready=0 in IDLE, STALL and DONE.
REQ-010 SHALL define a beat as accepted when m_tvalid && m_tready.
REQ-011 SHALL, in PASS with no pending match, connect the streams combinationally with zero latency: m_tvalid=s_tvalid, s_tready=m_tready, m_tdata=s_tdata, m_tlast=s_tlast.
REQ-012 SHALL treat an entry as a pending match when it is valid, unused, has cfg_len!=0, and its cfg_beat equals beat_cnt.
REQ-013 SHALL, in PASS with a pending match:
  - select the lowest-address matching entry;
  - gate the handshake that cycle;
  - mark the entry used;
  - load the stall counter with len-1;
  - go to STALL if len>1, otherwise stay in PASS.
REQ-014 SHALL, in STALL, decrement the counter each cycle and return to PASS in the cycle after the counter reads 0, so one entry gates exactly len consecutive cycles.
REQ-015 SHALL serve multiple entries with equal cfg_beat back-to-back in ascending address order, giving a total stall equal to the sum of their lengths.
REQ-016 SHALL clear beat_cnt on start and increment it by one per accepted beat; it SHALL saturate at 2^IDX_W-1.
REQ-017 SHALL go PASS->DONE on an accepted beat with m_tlast=1, and DONE->IDLE unconditionally one cycle later.
REQ-018 SHALL never fire entries with cfg_beat greater than the final beat index.
REQ-019 SHALL mark all entries unused again on start, so the schedule replays per transaction.
REQ-020 SHALL accept cfg_we and cfg_clear only in IDLE and ignore them otherwise.
REQ-021 SHALL give cfg_clear priority over a simultaneous cfg_we.
REQ-022 SHALL have a cfg_we write take effect for a start in the following cycle or later.
REQ-023 SHALL honour stalls requested at beat_cnt=0, gating the stream before the first beat.

Reset
REQ-024 SHALL, on rst, within the same edge: enter IDLE, invalidate and mark unused all entries, and clear the stall counter, beat_cnt, busy and done.
REQ-025 SHALL abort a transaction when rst is asserted mid-transaction; no done pulse SHALL follow.
REQ-026 SHALL give rst priority over start, cfg_we and cfg_clear.

Structure
REQ-027 SHALL place the following in package axis_stall_pkg:
  - the FSM state enum;
  - the stall-entry struct {valid, used, beat, len};
  - default parameter constants.
REQ-028 SHALL implement the entry storage and lowest-address match encoder in sub-module axis_stall_table; the FSM, counters and muxing SHALL live in the top module.

Verification
REQ-029 SHALL cover an empty table: 4-beat transaction, m_tready=1 -> 4 beats in 4 consecutive cycles, done pulse, beat_cnt=4.
REQ-030 SHALL cover a mid-transaction stall: entry{beat=2,len=3}, 6 beats -> exactly 3 gated cycles between beats 1 and 2, data order preserved.
REQ-031 SHALL cover end-point stalls:
  - entries{0,1} and {5,2} on a 6-beat transaction;
  - expect 1 gated cycle before beat 0;
  - expect 2 gated cycles before beat 5 (the tlast beat).
REQ-032 SHALL cover same-beat entries: addr1{3,2} and addr0{3,4} -> 6 consecutive gated cycles before beat 3; len=0 entry {1,0} -> no stall.
REQ-033 SHALL cover backpressure plus replay:
  - m_tready toggling with entry{1,2};
  - expect the stall inserted only once;
  - a second start replays the identical stall.
REQ-034 SHALL cover reset and configuration corner cases:
  - rst asserted in STALL -> IDLE next cycle, busy=0, no done pulse, table invalid;
  - cfg_we while busy -> table unchanged.
